// File: rtl/id_stage_decode.sv
`default_nettype none
// =============================================================================
// Module      : id_stage_decode
// Description : Instruction-decode stage: 15-entry register file, control
//               decoder, condition check and ID/EXE pipeline register.
//               Optional macro REGFILE_BYPASS_EN selects a posedge register
//               file with write-through reads instead of a negedge write.
// Revision    : 1.0 - initial release
// =============================================================================
module id_stage_decode #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [31:0]       Instruction,
    input  logic [3:0]        status,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_value,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic              two_src,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] Val_Rn,
    output logic [DATA_W-1:0] Val_Rm,
    output logic              Imm,
    output logic [11:0]       Shift_operand,
    output logic [23:0]       Signed_imm_24,
    output logic [3:0]        Dest,
    output logic [3:0]        EXE_CMD,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              WB_EN,
    output logic              S,
    output logic              B
);

    localparam logic [1:0] c_MODE_DP  = 2'b00;
    localparam logic [1:0] c_MODE_MEM = 2'b01;
    localparam logic [1:0] c_MODE_BR  = 2'b10;

    logic [1:0]        w_mode;
    logic [3:0]        w_cmd;
    logic              w_mem_r;
    logic              w_mem_w;
    logic              w_wb;
    logic              w_s;
    logic              w_b;
    logic              w_cond_pass;
    logic              w_wr;
    logic [DATA_W-1:0] w_val_rn;
    logic [DATA_W-1:0] w_val_rm;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    assign w_mode = Instruction[27:26];

    // Control decoder (condition-independent)
    always_comb begin
        w_cmd   = 4'b0000;
        w_mem_r = 1'b0;
        w_mem_w = 1'b0;
        w_wb    = 1'b0;
        w_s     = 1'b0;
        w_b     = 1'b0;
        case (w_mode)
            c_MODE_DP: begin
                w_wb = 1'b1;
                w_s  = Instruction[20];
                case (Instruction[24:21])
                    4'b1101: w_cmd = 4'b0001;
                    4'b1111: w_cmd = 4'b1001;
                    4'b0100: w_cmd = 4'b0010;
                    4'b0101: w_cmd = 4'b0011;
                    4'b0010: w_cmd = 4'b0100;
                    4'b0110: w_cmd = 4'b0101;
                    4'b0000: w_cmd = 4'b0110;
                    4'b1100: w_cmd = 4'b0111;
                    4'b0001: w_cmd = 4'b1000;
                    4'b1010: begin w_cmd = 4'b0100; w_wb = 1'b0; w_s = 1'b1; end
                    4'b1000: begin w_cmd = 4'b0110; w_wb = 1'b0; w_s = 1'b1; end
                    default: begin w_wb = 1'b0; w_s = 1'b0; end
                endcase
            end
            c_MODE_MEM: begin
                w_cmd = 4'b0010;
                if (Instruction[20]) begin
                    w_mem_r = 1'b1;
                    w_wb    = 1'b1;
                    w_s     = 1'b1;
                end else begin
                    w_mem_w = 1'b1;
                end
            end
            c_MODE_BR: w_b = 1'b1;
            default: ;
        endcase
    end

    // status = {N,Z,C,V}
    always_comb begin
        w_cond_pass = 1'b0;
        case (Instruction[31:28])
            4'b0000: w_cond_pass = status[2];
            4'b0001: w_cond_pass = ~status[2];
            4'b0010: w_cond_pass = status[1];
            4'b0011: w_cond_pass = ~status[1];
            4'b0100: w_cond_pass = status[3];
            4'b0101: w_cond_pass = ~status[3];
            4'b0110: w_cond_pass = status[0];
            4'b0111: w_cond_pass = ~status[0];
            4'b1000: w_cond_pass = status[1] & ~status[2];
            4'b1001: w_cond_pass = ~status[1] | status[2];
            4'b1010: w_cond_pass = (status[3] == status[0]);
            4'b1011: w_cond_pass = (status[3] != status[0]);
            4'b1100: w_cond_pass = ~status[2] & (status[3] == status[0]);
            4'b1101: w_cond_pass = status[2] | (status[3] != status[0]);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign src1    = Instruction[19:16];
    assign src2    = (w_mode == c_MODE_MEM && !Instruction[20]) ? Instruction[15:12] : Instruction[3:0];
    assign two_src = ~Instruction[25] | w_mem_w;

    // Index 15 is never a storage location; it aliases the PC
    assign w_wr = wb_en && (wb_dest < 4'(NUM_REGS));

`ifdef REGFILE_BYPASS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[wb_dest] <= wb_value;
        end
    end
`else
    // Negedge write makes the new value readable before the next posedge
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[wb_dest] <= wb_value;
        end
    end
`endif

    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] idx);
        logic [DATA_W-1:0] v;
        if (idx >= 4'(NUM_REGS))
            v = PC_in;
`ifdef REGFILE_BYPASS_EN
        else if (w_wr && (wb_dest == idx))
            v = wb_value;
`endif
        else
            v = r_regs[idx];
        return v;
    endfunction

    always_comb begin
        w_val_rn = rf_read(src1);
        w_val_rm = rf_read(src2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            PC            <= '0;
            Val_Rn        <= '0;
            Val_Rm        <= '0;
            Imm           <= 1'b0;
            Shift_operand <= '0;
            Signed_imm_24 <= '0;
            Dest          <= '0;
            EXE_CMD       <= '0;
            MEM_R_EN      <= 1'b0;
            MEM_W_EN      <= 1'b0;
            WB_EN         <= 1'b0;
            S             <= 1'b0;
            B             <= 1'b0;
        end else begin
            PC            <= PC_in;
            Val_Rn        <= w_val_rn;
            Val_Rm        <= w_val_rm;
            Imm           <= Instruction[25];
            Shift_operand <= Instruction[11:0];
            Signed_imm_24 <= Instruction[23:0];
            Dest          <= Instruction[15:12];
            if (freeze || !w_cond_pass) begin
                EXE_CMD  <= '0;
                MEM_R_EN <= 1'b0;
                MEM_W_EN <= 1'b0;
                WB_EN    <= 1'b0;
                S        <= 1'b0;
                B        <= 1'b0;
            end else begin
                EXE_CMD  <= w_cmd;
                MEM_R_EN <= w_mem_r;
                MEM_W_EN <= w_mem_w;
                WB_EN    <= w_wb;
                S        <= w_s;
                B        <= w_b;
            end
        end
    end

endmodule
`default_nettype wire
